index_sequencer: RTL and testbench



---
 rtl/index_sequencer.sv | 109 ++++++++++
 tb/tb_index_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/index_sequencer.sv
// index_sequencer
//   Upstream producer for the 2-to-3 zero-extend stage. After an accepted
//   start it walks idx_out from START_IDX up to the latched limit, advancing
//   one value per valid_out/ready_in handshake, then pulses done for a cycle.
//
//   Optional feature (macro INDEX_SEQ_WRAP_EN): when start is high on the
//   final handshake, the index restarts at START_IDX without leaving RUN and
//   done pulses while valid_out stays high (continuous mode). With the macro
//   undefined, start is ignored in RUN and the final handshake always ends
//   the sequence.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a sequence (sampled in IDLE; also in RUN when wrap enabled)
//   limit     in   last index to emit, latched on accepted start
//   ready_in  in   downstream accepts idx_out this cycle
//   idx_out   out  current index to the zero-extender
//   valid_out out  idx_out is valid
//   busy      out  high in RUN and DONE
//   done      out  one-cycle pulse after the final index is accepted
//
// state | meaning
// IDLE  | waiting for start, valid_out low
// RUN   | presenting idx_out, advancing on each handshake
// DONE  | final index accepted, done pulse, return to IDLE
//
// All outputs are flops, so ready_in has no combinational path to any output.

module index_sequencer #(
  parameter int              IDX_W     = 2,
  parameter logic [IDX_W-1:0] START_IDX = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] limit,
  input  logic             ready_in,
  output logic [IDX_W-1:0] idx_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] limit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      limit_q   <= '0;
      idx_out   <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            limit_q   <= limit;
            idx_out   <= START_IDX;
            valid_out <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // valid_out is always high in RUN, so ready_in alone is the handshake
          if (ready_in) begin
            if (idx_out != limit_q) begin
              idx_out <= idx_out + 1'b1;
            end else begin
              done <= 1'b1;
`ifdef INDEX_SEQ_WRAP_EN
              if (start) begin
                // continuous mode: restart without dropping valid_out
                idx_out <= START_IDX;
              end else begin
                valid_out <= 1'b0;
                state     <= DONE;
              end
`else
              valid_out <= 1'b0;
              state     <= DONE;
`endif
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid_out <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_index_sequencer.sv
module tb_index_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] limit;
  logic       ready_in;
  logic [1:0] idx_out;
  logic       valid_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model: the sequence still to be emitted is a queue of values.
  int  m_q[$];
  int  m_lim;
  bit  m_done;
  bit  m_in_done;
  int  accepted[$];

  localparam int START = 0;

  index_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .limit    (limit),
    .ready_in (ready_in),
    .idx_out  (idx_out),
    .valid_out(valid_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_fill();
    for (int v = START; v <= m_lim; v++) m_q.push_back(v);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lim     = 0;
    m_done    = 0;
    m_in_done = 0;
  endtask

  task automatic model_step(input bit s, input int l, input bit r);
    bit nd, nin;
    nd  = 0;
    nin = 0;
    if (m_q.size() > 0) begin
      if (r) begin
        accepted.push_back(m_q.pop_front());
        if (m_q.size() == 0) begin
          nd = 1;
`ifdef INDEX_SEQ_WRAP_EN
          if (s) model_fill();
          else nin = 1;
`else
          nin = 1;
`endif
        end
      end
    end else if (!m_in_done && s) begin
      m_lim = l;
      model_fill();
    end
    m_done    = nd;
    m_in_done = nin;
  endtask

  task automatic check_outputs();
    chk("valid_out", int'(valid_out), (m_q.size() > 0) ? 1 : 0);
    chk("busy", int'(busy), (m_q.size() > 0 || m_in_done) ? 1 : 0);
    chk("done", int'(done), int'(m_done));
    if (m_q.size() > 0) chk("idx_out", int'(idx_out), m_q[0]);
  endtask

  // Check outputs, apply inputs, clock, advance model; ends at a negedge.
  task automatic do_cycle(input bit s, input logic [1:0] l, input bit r);
    check_outputs();
    start    = s;
    limit    = l;
    ready_in = r;
    @(posedge clk);
    model_step(s, int'(l), r);
    @(negedge clk);
  endtask

  task automatic expect_accepted(input string tag, input int n, input int last);
    chk({tag, "_count"}, accepted.size(), n);
    for (int i = 0; i < accepted.size(); i++)
      chk({tag, "_order"}, accepted[i], (i > last) ? -1 : i);
    accepted.delete();
  endtask

  initial begin
    bit pat[5];
    rst = 1'b1; start = 1'b0; limit = 2'd0; ready_in = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_idx", int'(idx_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    do_cycle(0, 2'd0, 0);

    // limit=3, ready always high
    do_cycle(1, 2'd3, 1);
    for (int i = 0; i < 7; i++) do_cycle(0, 2'd3, 1);
    expect_accepted("lim3", 4, 3);

    // limit=0 emits a single 0
    do_cycle(1, 2'd0, 1);
    for (int i = 0; i < 4; i++) do_cycle(0, 2'd0, 1);
    expect_accepted("lim0", 1, 0);

    // limit=2 with stalls
    pat = '{1, 0, 0, 1, 1};
    do_cycle(1, 2'd2, 0);
    for (int i = 0; i < 5; i++) do_cycle(0, 2'd2, pat[i]);
    for (int i = 0; i < 3; i++) do_cycle(0, 2'd2, 1);
    expect_accepted("lim2", 3, 2);

    // start and limit changes while busy are ignored
    do_cycle(1, 2'd3, 0);
    do_cycle(0, 2'd3, 1);
    do_cycle(1, 2'd0, 0);
    do_cycle(0, 2'd0, 0);
    for (int i = 0; i < 6; i++) do_cycle(0, 2'd0, 1);
    expect_accepted("busy_ign", 4, 3);

    // async reset between edges mid-RUN
    do_cycle(1, 2'd3, 0);
    do_cycle(0, 2'd3, 1);
    @(posedge clk);
    model_step(0, 3, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_idx", int'(idx_out), 0);
    chk("arst_valid", int'(valid_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    model_reset();
    accepted.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle(0, 2'd3, 1);

`ifdef INDEX_SEQ_WRAP_EN
    // continuous mode: 0,1,0,1,... then drop start
    do_cycle(1, 2'd1, 1);
    for (int i = 0; i < 8; i++) do_cycle(1, 2'd1, 1);
    for (int i = 0; i < 5; i++) do_cycle(0, 2'd1, 1);
    chk("wrap_count", accepted.size(), 10);
    for (int i = 0; i < accepted.size(); i++) chk("wrap_order", accepted[i], i % 2);
    accepted.delete();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++)
      do_cycle(($urandom % 4) == 0, 2'($urandom), ($urandom % 3) != 0);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
